// File: rtl/palette_lut_pipe.sv
// palette_lut_pipe: run-time programmable colour palette lookup.
// Maps a colour index to a packed {R,G,B} word through a registered
// valid/ready pipeline: S1 holds the index and S2 holds the looked-up colour.
// The palette is a flop array. On reset it loads the primary/secondary colour
// set into entries 0..7 and clears every other entry.
// Writes are never blocked by back-pressure. A write to the address that S2 is
// capturing on the same edge is forwarded into S2.
// Optional feature macro PALETTE_BRIGHT_EN: adds stage S3, which scales each
// channel by (bright+1)/2**CH_W. When the macro is undefined, bright is ignored.

module palette_lut_pipe #(
   parameter int ADDR_W = 3,
   parameter int CH_W   = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [ADDR_W-1:0]   in_index,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [3*CH_W-1:0]   out_rgb,
   input  logic                wr_en,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [3*CH_W-1:0]   wr_data,
   input  logic [CH_W-1:0]     bright
);

   localparam int DATA_W = 3 * CH_W;
   localparam int DEPTH  = 1 << ADDR_W;

   logic [DATA_W-1:0] palette [DEPTH];
   logic              advance;
   logic              s1_valid;
   logic [ADDR_W-1:0] s1_index;
   logic              s2_valid;
   logic [DATA_W-1:0] s2_rgb;
   logic [DATA_W-1:0] lookup;

   // Entries 0..7: index bits {2,1,0} select full-scale {R,G,B}; higher entries are black
   function automatic logic [DATA_W-1:0] default_entry(input int idx);
      logic [DATA_W-1:0] e;
      e = '0;
      if (idx < 8) begin
         e = {{CH_W{idx[2]}}, {CH_W{idx[1]}}, {CH_W{idx[0]}}};
      end
      return e;
   endfunction

   // The whole pipeline moves as one; a held result at the output freezes every stage
   assign advance  = ~out_valid | out_ready;
   assign in_ready = advance;

   // Palette storage: reset to the default colours, then rewritten by the write port
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            palette[i] <= default_entry(i);
         end
      end else if (wr_en) begin
         palette[wr_addr] <= wr_data;
      end
   end

   // Read with write-first forwarding so S2 never captures a stale entry
   always_comb begin
      lookup = palette[s1_index];
      if (wr_en && (wr_addr == s1_index)) begin
         lookup = wr_data;
      end
   end

   // S1 captures the request; bubbles travel as valid=0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_index <= '0;
      end else if (advance) begin
         s1_valid <= in_valid;
         s1_index <= in_index;
      end
   end

   // S2 captures the colour; while stalled it keeps the value it already captured
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid <= 1'b0;
         s2_rgb   <= '0;
      end else if (advance) begin
         s2_valid <= s1_valid;
         s2_rgb   <= lookup;
      end
   end

`ifdef PALETTE_BRIGHT_EN
   logic              s3_valid;
   logic [DATA_W-1:0] s3_rgb;

   // One channel scaled by (b+1) at double width, then the top CH_W bits are kept
   function automatic logic [CH_W-1:0] scale_ch(input logic [CH_W-1:0] ch,
                                                input logic [CH_W-1:0] b);
      logic [2*CH_W-1:0] prod;
      prod = (2*CH_W)'(ch) * ((2*CH_W)'(b) + (2*CH_W)'(1));
      return CH_W'(prod >> CH_W);
   endfunction

   // All three channels scaled by the same factor
   function automatic logic [DATA_W-1:0] scale_rgb(input logic [DATA_W-1:0] rgb,
                                                   input logic [CH_W-1:0] b);
      logic [DATA_W-1:0] r;
      r = '0;
      for (int c = 0; c < 3; c++) begin
         r[c*CH_W +: CH_W] = scale_ch(rgb[c*CH_W +: CH_W], b);
      end
      return r;
   endfunction

   // S3 applies brightness, with bright sampled on the same advance as the data
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3_valid <= 1'b0;
         s3_rgb   <= '0;
      end else if (advance) begin
         s3_valid <= s2_valid;
         s3_rgb   <= scale_rgb(s2_rgb, bright);
      end
   end

   assign out_valid = s3_valid;
   assign out_rgb   = s3_rgb;
`else
   logic unused_bright;

   assign unused_bright = ^bright;
   assign out_valid     = s2_valid;
   assign out_rgb       = s2_rgb;
`endif

endmodule
